// File: rtl/id_hazard_ctrl.sv
// ID-stage scoreboard: tracks pending register writers, stalls ID on RAW and
// over-depth WAW hazards, and kills wrong-path slots after an EX redirect.
// No forwarding here; a consumer waits until its producer has retired.
module id_hazard_ctrl #(
  parameter int REG_NUM      = 32,
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               id_pipe_valid,
  input  logic               ex_pipe_ready,
  input  logic               id_rs1_read,
  input  logic [REG_AW-1:0]  id_rs1_addr,
  input  logic               id_rs2_read,
  input  logic [REG_AW-1:0]  id_rs2_addr,
  input  logic               id_rd_write,
  input  logic [REG_AW-1:0]  id_rd_addr,
  input  logic               ex_flush,
  input  logic               wb_rd_write,
  input  logic [REG_AW-1:0]  wb_rd_addr,
  output logic               id_stall,
  output logic               id_kill,
  output logic               id_issue,
  output logic [REG_NUM-1:0] sb_busy,
  output logic               sb_err
);

  localparam int KW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [KW-1:0]    KILL_LD  = KW'(FLUSH_CYCLES);
  localparam logic [KW-1:0]    KILL_ONE = KW'(1);

  logic [REG_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]                 kill_cnt_q, kill_cnt_d;
  logic                          sb_err_q, sb_err_d;

  logic rs1_hz, rs2_hz, waw_hz;
  logic kill_raw, stall_raw, issue_raw;
  logic inc, dec;

  // Hazard, kill and issue qualifiers; all look only at registered counts,
  // and all three are held low while reset is asserted.
  always_comb begin
    rs1_hz    = id_rs1_read & (id_rs1_addr != '0) & (cnt_q[id_rs1_addr] != '0);
    rs2_hz    = id_rs2_read & (id_rs2_addr != '0) & (cnt_q[id_rs2_addr] != '0);
    waw_hz    = id_rd_write & (id_rd_addr  != '0) & (cnt_q[id_rd_addr] == CNT_MAX);
    kill_raw  = ex_flush | (kill_cnt_q != '0);
    stall_raw = id_pipe_valid & ~kill_raw & (rs1_hz | rs2_hz | waw_hz);
    issue_raw = id_pipe_valid & ex_pipe_ready & ~stall_raw & ~kill_raw;
    id_kill   = kill_raw  & ~rst_b;
    id_stall  = stall_raw & ~rst_b;
    id_issue  = issue_raw & ~rst_b;
  end

  // Kill window: reload on every flush, count down only on consumed slots.
  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (ex_flush)
      kill_cnt_d = KILL_LD;
    else if ((kill_cnt_q != '0) && id_pipe_valid && ex_pipe_ready)
      kill_cnt_d = kill_cnt_q - KILL_ONE;
  end

  // Scoreboard next state: issue increments rd, retire decrements wb_rd,
  // a matched pair on one register cancels. x0 is never tracked.
  always_comb begin
    inc      = issue_raw & id_rd_write & (id_rd_addr != '0);
    dec      = wb_rd_write & (wb_rd_addr != '0);
    cnt_d    = cnt_q;
    cnt_d[0] = '0;
    sb_err_d = sb_err_q;
    for (int i = 1; i < REG_NUM; i++) begin
      logic inc_i, dec_i;
      inc_i = inc & (id_rd_addr == REG_AW'(i));
      dec_i = dec & (wb_rd_addr == REG_AW'(i));
      if (inc_i && !dec_i)
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (dec_i && !inc_i) begin
        if (cnt_q[i] == '0) sb_err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      cnt_q      <= '0;
      kill_cnt_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      kill_cnt_q <= kill_cnt_d;
      sb_err_q   <= sb_err_d;
    end
  end

  // Busy view of the registered counts.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++)
      sb_busy[i] = (cnt_q[i] != '0);
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios plus random traffic, all
// compared against an integer reference model of the scoreboard rules.
module tb_id_hazard_ctrl;

  localparam int MAXC = 3;   // 2^CNT_W - 1
  localparam int FLC  = 1;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        id_pipe_valid = 0, ex_pipe_ready = 0;
  logic        id_rs1_read = 0, id_rs2_read = 0, id_rd_write = 0;
  logic [4:0]  id_rs1_addr = 0, id_rs2_addr = 0, id_rd_addr = 0;
  logic        ex_flush = 0, wb_rd_write = 0;
  logic [4:0]  wb_rd_addr = 0;
  logic        id_stall, id_kill, id_issue, sb_err;
  logic [31:0] sb_busy;

  id_hazard_ctrl dut (
    .clk(clk), .rst_b(rst_b),
    .id_pipe_valid(id_pipe_valid), .ex_pipe_ready(ex_pipe_ready),
    .id_rs1_read(id_rs1_read), .id_rs1_addr(id_rs1_addr),
    .id_rs2_read(id_rs2_read), .id_rs2_addr(id_rs2_addr),
    .id_rd_write(id_rd_write), .id_rd_addr(id_rd_addr),
    .ex_flush(ex_flush), .wb_rd_write(wb_rd_write), .wb_rd_addr(wb_rd_addr),
    .id_stall(id_stall), .id_kill(id_kill), .id_issue(id_issue),
    .sb_busy(sb_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference model state
  int cnt_m[32];
  int kill_m;
  bit err_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    kill_m = 0;
    err_m  = 0;
  endfunction

  function automatic logic [31:0] busy_m();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = (cnt_m[i] != 0);
    return b;
  endfunction

  // One cycle: drive after the falling edge, check combinational outputs and
  // registered state against the model, then advance the model at the rise.
  task automatic cyc(input bit v, input bit rdy,
                     input bit r1, input int a1, input bit r2, input int a2,
                     input bit w, input int rd, input bit fl,
                     input bit wb, input int wa, input string tag);
    bit kill, hz, stall, issue, inc, dec;
    id_pipe_valid = v;  ex_pipe_ready = rdy;
    id_rs1_read = r1;   id_rs1_addr = 5'(a1);
    id_rs2_read = r2;   id_rs2_addr = 5'(a2);
    id_rd_write = w;    id_rd_addr  = 5'(rd);
    ex_flush = fl;      wb_rd_write = wb; wb_rd_addr = 5'(wa);
    kill  = fl || (kill_m > 0);
    hz    = (r1 && a1 != 0 && cnt_m[a1] > 0) || (r2 && a2 != 0 && cnt_m[a2] > 0) ||
            (w && rd != 0 && cnt_m[rd] == MAXC);
    stall = v && !kill && hz;
    issue = v && rdy && !stall && !kill;
    #1;
    chk({tag, ".kill"},  32'(id_kill),  32'(kill));
    chk({tag, ".stall"}, 32'(id_stall), 32'(stall));
    chk({tag, ".issue"}, 32'(id_issue), 32'(issue));
    chk({tag, ".busy"},  sb_busy,       busy_m());
    chk({tag, ".err"},   32'(sb_err),   32'(err_m));
    inc = issue && w && rd != 0;
    dec = wb && wa != 0;
    if (inc && dec && rd == wa) ;
    else begin
      if (inc) cnt_m[rd]++;
      if (dec) begin
        if (cnt_m[wa] == 0) err_m = 1;
        else cnt_m[wa]--;
      end
    end
    if (fl) kill_m = FLC;
    else if (kill_m > 0 && v && rdy) kill_m--;
    @(negedge clk);
  endtask

  function automatic int pick_reg();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 5;
      4: return 7;
      default: return $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    model_reset();
    #12 rst_b = 1'b0;           // release away from the rising edge
    @(negedge clk);

    // reset state with idle inputs
    cyc(0,0, 0,0, 0,0, 0,0, 0, 0,0, "rst");

    // RAW on x5, retire releases one cycle late
    cyc(1,1, 0,0, 0,0, 1,5, 0, 0,0, "t1.wr5");
    chk("t1.busy5", 32'(sb_busy[5]), 32'd1);
    cyc(1,1, 1,5, 0,0, 0,0, 0, 0,0, "t1.raw");
    cyc(1,1, 1,5, 0,0, 0,0, 0, 1,5, "t1.ret");
    chk("t1.busy5_clr", 32'(sb_busy[5]), 32'd0);
    cyc(1,1, 1,5, 0,0, 0,0, 0, 0,0, "t1.go");

    // x0 never hazards nor tracks
    cyc(1,1, 1,0, 1,0, 0,0, 0, 0,0, "t2.rd0");
    cyc(1,1, 0,0, 0,0, 1,0, 0, 0,0, "t2.wr0");
    chk("t2.busy", sb_busy, 32'd0);

    // WAW depth limit on x7
    repeat (3) cyc(1,1, 0,0, 0,0, 1,7, 0, 0,0, "t3.wr7");
    cyc(1,1, 0,0, 0,0, 1,7, 0, 1,7, "t3.waw");
    chk("t3.stall_expect", 32'(id_stall), 32'd0); // ID moved on: sampled after edge
    cyc(1,1, 0,0, 0,0, 1,7, 0, 0,0, "t3.go");
    repeat (3) cyc(0,0, 0,0, 0,0, 0,0, 0, 1,7, "t3.drain");

    // simultaneous inc/dec on x9
    cyc(1,1, 0,0, 0,0, 1,9, 0, 0,0, "t4.set");
    cyc(1,1, 0,0, 0,0, 1,9, 0, 1,9, "t4.both");
    chk("t4.busy9", 32'(sb_busy[9]), 32'd1);
    chk("t4.err",   32'(sb_err),     32'd0);
    cyc(0,0, 0,0, 0,0, 0,0, 0, 1,9, "t4.drain");

    // flush over a hazard, then back-pressure holds the kill window
    cyc(1,1, 0,0, 0,0, 1,3, 0, 0,0, "t5.wr3");
    cyc(1,1, 1,3, 0,0, 0,0, 1, 0,0, "t5.flush");
    repeat (3) cyc(1,0, 1,3, 0,0, 0,0, 0, 0,0, "t5.hold");
    cyc(1,1, 0,0, 0,0, 0,0, 0, 0,0, "t5.kill2");
    cyc(1,1, 0,0, 0,0, 0,0, 0, 0,0, "t5.live");
    cyc(0,0, 0,0, 0,0, 0,0, 0, 1,3, "t5.drain");

    // retire to idle x12 -> sticky error
    cyc(0,0, 0,0, 0,0, 0,0, 0, 1,12, "t6.err");
    chk("t6.err_set", 32'(sb_err), 32'd1);
    cyc(0,0, 0,0, 0,0, 0,0, 0, 0,0, "t6.sticky");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int wa; bit wb;
      wa = pick_reg();
      wb = ($urandom_range(0, 1) == 1) && (cnt_m[wa] != 0 || $urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1), pick_reg(), $urandom_range(0, 1), pick_reg(),
          $urandom_range(0, 1), pick_reg(), $urandom_range(0, 15) == 0,
          wb, wa, "rnd");
    end

    // async reset mid-cycle with pending writers and an active flush
    cyc(1,1, 0,0, 0,0, 1,4, 0, 0,0, "t6.pre");
    id_pipe_valid = 1; ex_pipe_ready = 1; ex_flush = 1;
    id_rs1_read = 1; id_rs1_addr = 5'd4;
    #2 rst_b = 1'b1;
    #1;
    chk("t6.rst_busy",  sb_busy,          32'd0);
    chk("t6.rst_err",   32'(sb_err),      32'd0);
    chk("t6.rst_kill",  32'(id_kill),     32'd0);
    chk("t6.rst_stall", 32'(id_stall),    32'd0);
    chk("t6.rst_issue", 32'(id_issue),    32'd0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b0;
    cyc(0,0, 0,0, 0,0, 0,0, 0, 0,0, "post_rst");
    cyc(1,1, 1,4, 0,0, 0,0, 0, 0,0, "post_rst.rd4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Scoreboard-based hazard and flush controller for the ID stage of the in-order RV32 pipeline (IF -> ID -> EX -> ... -> WB).
- Tracks in-flight register writes, stalls ID on RAW and over-depth WAW hazards, and kills wrong-path instructions after a taken branch or jump in EX.
- Drives the ID stall and kill qualifiers. It does not implement forwarding.

Parameters:
- REG_NUM, 32, number of architectural registers tracked.
- REG_AW, 5, register address width.
- CNT_W, 2, width of each per-register pending-writer counter. Maximum count is 2^CNT_W-1.
- FLUSH_CYCLES, 1, number of consumed ID slots killed after the flush cycle itself.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset. Asynchronous, active-high.
- id_pipe_valid  in  1  ID holds a valid instruction.
- ex_pipe_ready  in  1  EX can accept.
- id_rs1_read  in  1  instruction reads rs1.
- id_rs1_addr  in  REG_AW  rs1 index.
- id_rs2_read  in  1  instruction reads rs2.
- id_rs2_addr  in  REG_AW  rs2 index.
- id_rd_write  in  1  instruction writes rd.
- id_rd_addr  in  REG_AW  rd index.
- ex_flush  in  1  taken branch or jump resolved in EX.
- wb_rd_write  in  1  WB register write (retire).
- wb_rd_addr  in  REG_AW  WB destination.
- id_stall  out  1  hold ID; do not advance.
- id_kill  out  1  convert the ID instruction to a bubble.
- id_issue  out  1  ID instruction accepted by EX this cycle.
- sb_busy  out  REG_NUM  bit i = (cnt[i] != 0).
- sb_err  out  1  sticky: retire to a register with count 0.

Behaviour:
- State:
  - cnt[1..REG_NUM-1], CNT_W bits each. cnt[0] is hardwired 0.
  - kill_cnt, clog2(FLUSH_CYCLES+1) bits.
  - sb_err flop.
- Reset (async, while rst_b=1):
  - All cnt=0, kill_cnt=0, sb_err=0.
  - Outputs: sb_busy=0, sb_err=0, id_stall=0, id_kill=0, id_issue=0. All three combinational outputs are forced 0 during reset.
  - Reset mid-operation discards all pending state immediately.
- Kill:
  - id_kill = ex_flush | (kill_cnt != 0).
  - On ex_flush: kill_cnt <= FLUSH_CYCLES. A flush during an active kill window reloads kill_cnt.
  - Otherwise, when kill_cnt != 0 and id_pipe_valid & ex_pipe_ready: kill_cnt decrements. Only consumed slots count; idle or back-pressured cycles do not.
- Hazards. All use registered cnt only. There is no same-cycle WB bypass: a read of a register retiring this cycle still stalls this cycle and proceeds next cycle.
  - rs1_hz = id_rs1_read & id_rs1_addr != 0 & cnt[rs1] != 0.
  - rs2_hz = id_rs2_read & id_rs2_addr != 0 & cnt[rs2] != 0.
  - waw_hz = id_rd_write & id_rd_addr != 0 & cnt[rd] == max.
  - id_stall = id_pipe_valid & ~id_kill & (rs1_hz | rs2_hz | waw_hz). Kill has priority over stall.
- Issue:
  - id_issue = id_pipe_valid & ex_pipe_ready & ~id_stall & ~id_kill.
- Counter update (one edge after the event):
  - inc = id_issue & id_rd_write & id_rd_addr != 0.
  - dec = wb_rd_write & wb_rd_addr != 0.
  - inc and dec on the same register: count unchanged.
  - inc alone: +1. This never overflows, because waw_hz blocks issue at max.
  - dec alone: -1. If the count is 0, it stays 0 and sb_err <= 1 (sticky until reset).
  - inc and dec on different registers: both apply independently.
- Killed or stalled instructions never touch the scoreboard.
- sb_busy is derived combinationally from the registered counts. It changes only after a clock edge.
- Latency: hazard detection is same-cycle. The scoreboard reflects an issue or retire at the next cycle.

Test Plan:
1. Issue with rd=5 (id_issue=1) → next cycle sb_busy[5]=1. Following instruction with rs1=5 → id_stall=1, id_issue=0. WB retire x5 at cycle N → stall still 1 at N, id_issue=1 at N+1, sb_busy[5]=0 at N+1.
2. Instruction reads rs1=0, rs2=0 while all cnt=0; then writes rd=0 → no stall, sb_busy stays 0.
3. Three back-to-back issues with rd=7 and no retire → cnt[7]=3. A fourth writer of x7 → id_stall=1 (waw). One retire of x7 → fourth issues next cycle, cnt[7]=3.
4. cnt[9]=1; issue rd=9 and retire x9 in the same cycle → cnt[9] remains 1, sb_busy[9]=1, sb_err=0.
5. FLUSH_CYCLES=1; ex_flush pulse while ID holds an instruction reading a busy register → id_kill=1, id_stall=0, id_issue=0 that cycle.
   - Next consumed slot is also killed; the one after issues normally.
   - With ex_pipe_ready=0 for 3 cycles after the flush, kill_cnt holds at 1 until a slot is consumed.
6. Retire x12 with cnt[12]=0 → sb_err=1 and stays 1. Assert rst_b asynchronously mid-cycle with several counts non-zero → sb_busy=0, sb_err=0, id_kill=0 immediately, without waiting for a clock edge.
